// File: rtl/mul_err_monitor.sv
// Streaming error monitor for a 2x2-bit approximate multiplier: recomputes the exact
// product, accumulates error statistics over a run. Optional `MUL_ERR_SUM_EN` adds err_sum.
module mul_err_monitor #(
    parameter int ET    = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [3:0]       s_op,
    input  logic [3:0]       s_res,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [3:0]       max_err,
`ifdef MUL_ERR_SUM_EN
    output logic [CNT_W+3:0] err_sum,
`endif
    output logic             viol
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // A 4-bit error can never exceed a threshold of 15 or more.
    localparam logic ET_OFF = (ET >= 15);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q;
    logic             s1_vld_q;
    logic [3:0]       e1_q, e_d, exact;
    logic [CNT_W-1:0] err_cnt_q, viol_cnt_q;
    logic [3:0]       max_err_q;
    logic             viol_q;
    logic             xfer, start_go, viol_hit;

    assign xfer     = s_valid && s_ready;
    assign start_go = !clear && start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) state_d = (num_samples == '0) ? DONE : RUN;
                RUN:        if (xfer && rem_q == CNT_W'(1)) state_d = DRAIN;
                // Stage 1 retires into the statistics on this edge and nothing new enters.
                DRAIN:      state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready = (state_q == RUN);
        busy    = (state_q == RUN) || (state_q == DRAIN);
        done    = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rem_q <= '0;
        else if (clear)    rem_q <= '0;
        else if (start_go) rem_q <= num_samples;
        else if (xfer)     rem_q <= rem_q - CNT_W'(1);
    end

    // Stage 1: exact product and absolute error; a = op[1:0], b = op[3:2].
    assign exact = {2'b00, s_op[1:0]} * {2'b00, s_op[3:2]};
    assign e_d   = (exact >= s_res) ? (exact - s_res) : (s_res - exact);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            e1_q     <= '0;
        end else begin
            s1_vld_q <= xfer && !clear;
            if (xfer) e1_q <= e_d;
        end
    end

    assign viol_hit = !ET_OFF && (32'(e1_q) > 32'(ET));

    // Stage 2: saturating statistics. viol survives a new start, only clear drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            viol_cnt_q <= '0;
            max_err_q  <= '0;
            viol_q     <= 1'b0;
        end else if (clear) begin
            err_cnt_q  <= '0;
            viol_cnt_q <= '0;
            max_err_q  <= '0;
            viol_q     <= 1'b0;
        end else if (start_go) begin
            err_cnt_q  <= '0;
            viol_cnt_q <= '0;
            max_err_q  <= '0;
        end else if (s1_vld_q) begin
            if (e1_q != '0 && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (viol_hit && viol_cnt_q != '1) viol_cnt_q <= viol_cnt_q + CNT_W'(1);
            if (viol_hit) viol_q <= 1'b1;
            if (e1_q > max_err_q) max_err_q <= e1_q;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign viol_cnt = viol_cnt_q;
    assign max_err  = max_err_q;
    assign viol     = viol_q;

`ifdef MUL_ERR_SUM_EN
    logic [CNT_W+3:0] err_sum_q;
    logic [CNT_W+4:0] sum_d;

    assign sum_d = {1'b0, err_sum_q} + (CNT_W+5)'(e1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                err_sum_q <= '0;
        else if (clear || start_go) err_sum_q <= '0;
        else if (s1_vld_q)         err_sum_q <= sum_d[CNT_W+4] ? '1 : sum_d[CNT_W+3:0];
    end

    assign err_sum = err_sum_q;
`endif

endmodule

// File: tb/tb_mul_err_monitor.sv
// Directed bench for mul_err_monitor: a default instance (CNT_W=16, ET=2) and a CNT_W=4 instance.
module tb_mul_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n, start, clear, s_valid, s_ready, busy, done, viol;
    logic [15:0] num_samples, err_cnt, viol_cnt;
    logic [3:0]  s_op, s_res, max_err;
    logic        start2, s_valid2, s_ready2, busy2, done2, viol2;
    logic [3:0]  num2, s_op2, s_res2, err_cnt2, viol_cnt2, max_err2;
`ifdef MUL_ERR_SUM_EN
    logic [19:0] err_sum;
    logic [7:0]  err_sum2;
`endif
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_err_monitor #(.ET(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .num_samples(num_samples),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_res(s_res),
        .busy(busy), .done(done), .err_cnt(err_cnt), .viol_cnt(viol_cnt), .max_err(max_err),
`ifdef MUL_ERR_SUM_EN
        .err_sum(err_sum),
`endif
        .viol(viol)
    );

    mul_err_monitor #(.ET(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .clear(1'b0), .num_samples(num2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_op(s_op2), .s_res(s_res2),
        .busy(busy2), .done(done2), .err_cnt(err_cnt2), .viol_cnt(viol_cnt2), .max_err(max_err2),
`ifdef MUL_ERR_SUM_EN
        .err_sum(err_sum2),
`endif
        .viol(viol2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks are made there as well.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num_samples = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] res);
        s_valid = 1'b1;
        s_op = op;
        s_res = res;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; num_samples = '0;
        s_valid = 1'b0; s_op = '0; s_res = '0;
        start2 = 1'b0; num2 = '0; s_valid2 = 1'b0; s_op2 = '0; s_res2 = '0;
        #2;
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #10 rst_n = 1'b1;
        tick(); tick();

        // Mid-run reset with 5 samples remaining; two samples already reached the statistics.
        do_start(8);
        send(4'b0000, 4'd15); send(4'b0000, 4'd15); send(4'b0000, 4'd15);
        chk("pre_rst_err_cnt", err_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", s_ready, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_max_err", max_err, 0);
        chk("mid_rst_viol", viol, 0);
        chk("mid_rst_viol_cnt", viol_cnt, 0);
`ifdef MUL_ERR_SUM_EN
        chk("mid_rst_err_sum", err_sum, 0);
`endif
        s_valid = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", s_ready, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);

        // Exact products for all 16 operand words.
        do_start(16);
        for (int i = 0; i < 16; i++) send(4'(i), 4'((i % 4) * (i / 4)));
        s_valid = 1'b0;
        chk("exact_drain_busy", busy, 1);
        chk("exact_drain_ready", s_ready, 0);
        chk("exact_done_early", done, 0);
        tick();
        chk("exact_done", done, 1);
        chk("exact_busy", busy, 0);
        chk("exact_err_cnt", err_cnt, 0);
        chk("exact_viol_cnt", viol_cnt, 0);
        chk("exact_max_err", max_err, 0);
        chk("exact_viol", viol, 0);

        // Threshold boundary: e = 2, 4, 15 with ET = 2.
        do_start(3);
        send(4'b1111, 4'd7); send(4'b1111, 4'd5); send(4'b0000, 4'd15);
        s_valid = 1'b0;
        tick();
        chk("thr_done", done, 1);
        chk("thr_err_cnt", err_cnt, 3);
        chk("thr_viol_cnt", viol_cnt, 2);
        chk("thr_max_err", max_err, 15);
        chk("thr_viol", viol, 1);
`ifdef MUL_ERR_SUM_EN
        chk("thr_err_sum", err_sum, 21);
`endif

        // Restart from DONE clears counters but keeps the sticky flag; then bubbles.
        do_start(8);
        chk("restart_err_cnt", err_cnt, 0);
        chk("restart_max_err", max_err, 0);
        chk("restart_viol", viol, 1);
        chk("restart_busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            s_valid = (i % 2 == 0);
            s_op = 4'b0101;
            s_res = 4'd0;
            tick();
        end
        chk("bub_done", done, 1);
        chk("bub_err_cnt", err_cnt, 8);
        chk("bub_viol_cnt", viol_cnt, 0);
        chk("bub_max_err", max_err, 1);
        s_valid = 1'b1;
        chk("done_ready", s_ready, 0);
        tick(); tick();
        chk("done_hold_err_cnt", err_cnt, 8);
        s_valid = 1'b0;

        // Zero-length run.
        do_start(0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_err_cnt", err_cnt, 0);

        // Start during RUN is ignored.
        do_start(4);
        send(4'b0101, 4'd0); send(4'b0101, 4'd0);
        start = 1'b1; num_samples = 16'd10;
        send(4'b0101, 4'd0);
        start = 1'b0;
        send(4'b0101, 4'd0);
        s_valid = 1'b0;
        chk("ign_drain_busy", busy, 1);
        tick();
        chk("ign_done", done, 1);
        chk("ign_err_cnt", err_cnt, 4);

        // Clear in DONE, asserted together with start.
        clear = 1'b1; start = 1'b1; num_samples = 16'd5;
        tick();
        clear = 1'b0; start = 1'b0;
        chk("clr_done", done, 0);
        chk("clr_busy", busy, 0);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_viol_cnt", viol_cnt, 0);
        chk("clr_max_err", max_err, 0);
        chk("clr_viol", viol, 0);
        tick();
        chk("clr_idle_busy", busy, 0);

        // CNT_W = 4: 20 erroneous samples offered, counters top out at 15.
        start2 = 1'b1; num2 = 4'd15;
        tick();
        start2 = 1'b0;
        s_valid2 = 1'b1; s_op2 = 4'b0000; s_res2 = 4'd15;
        repeat (20) tick();
        s_valid2 = 1'b0;
        tick(); tick();
        chk("sat_done", done2, 1);
        chk("sat_err_cnt", err_cnt2, 15);
        chk("sat_viol_cnt", viol_cnt2, 15);
        chk("sat_max_err", max_err2, 15);
`ifdef MUL_ERR_SUM_EN
        chk("sat_err_sum", err_sum2, 225);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
